// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: FSM state encoding (common with the transmitter)
// and the oversampling tick positions within a bit.
package uart_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } state_t;

  localparam logic [4:0] MID_TICK  = 5'd7;
  localparam logic [4:0] LAST_TICK = 5'd15;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous input pin, with a configurable
// reset value so an idle-high line does not look active out of reset.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic meta_r;
  logic sync_r;

  // Synchroniser chain.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meta_r <= RST_VAL;
      sync_r <= RST_VAL;
    end else begin
      meta_r <= i_d;
      sync_r <= meta_r;
    end
  end

  assign o_q = sync_r;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled 8N1 (LSB first) frame recovery with
// registered data, one-cycle done / framing-error strobes and a busy flag.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_tick,
  input  logic            i_rx,
  output logic [DBIT-1:0] o_data,
  output logic            o_rx_done,
  output logic            o_frame_err,
  output logic            o_busy
);

  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [NW-1:0] N_LAST    = NW'(DBIT - 1);
  localparam logic [4:0]    STOP_LAST = 5'(SB_TICK - 1);

  logic            rx_s;
  state_t          state_r, state_n;
  logic [4:0]      s_r, s_n;
  logic [NW-1:0]   n_r, n_n;
  logic [DBIT-1:0] b_r, b_n;
  logic [DBIT-1:0] data_r, data_n;
  logic            done_r, done_n;
  logic            ferr_r, ferr_n;
  logic            busy_r;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_rx),
    .o_q     (rx_s)
  );

  // State, counters, shift register and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= IDLE;
      s_r     <= 5'd0;
      n_r     <= '0;
      b_r     <= '0;
      data_r  <= '0;
      done_r  <= 1'b0;
      ferr_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      s_r     <= s_n;
      n_r     <= n_n;
      b_r     <= b_n;
      data_r  <= data_n;
      done_r  <= done_n;
      ferr_r  <= ferr_n;
      busy_r  <= (state_n != IDLE);
    end
  end

  // Next-state and datapath logic; counters only move on a tick.
  always_comb begin
    state_n = state_r;
    s_n     = s_r;
    n_n     = n_r;
    b_n     = b_r;
    data_n  = data_r;
    done_n  = 1'b0;
    ferr_n  = 1'b0;
    case (state_r)
      IDLE: begin
        if (!rx_s) begin
          state_n = START;
          s_n     = 5'd0;
        end else begin
          state_n = IDLE;
        end
      end
      START: begin
        if (i_tick) begin
          if (s_r == MID_TICK) begin
            // A start bit that is high again at mid-bit was only a glitch.
            if (!rx_s) begin
              state_n = DATA;
              s_n     = 5'd0;
              n_n     = '0;
            end else begin
              state_n = IDLE;
            end
          end else begin
            s_n = s_r + 5'd1;
          end
        end else begin
          state_n = START;
        end
      end
      DATA: begin
        if (i_tick) begin
          if (s_r == LAST_TICK) begin
            s_n = 5'd0;
            b_n = {rx_s, b_r[DBIT-1:1]};
            if (n_r == N_LAST) begin
              state_n = STOP;
            end else begin
              n_n = n_r + NW'(1'b1);
            end
          end else begin
            s_n = s_r + 5'd1;
          end
        end else begin
          state_n = DATA;
        end
      end
      STOP: begin
        if (i_tick) begin
          if (s_r == STOP_LAST) begin
            state_n = IDLE;
            if (rx_s) begin
              data_n = b_r;
              done_n = 1'b1;
            end else begin
              ferr_n = 1'b1;
            end
          end else begin
            s_n = s_r + 5'd1;
          end
        end else begin
          state_n = STOP;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign o_data      = data_r;
  assign o_rx_done   = done_r;
  assign o_frame_err = ferr_r;
  assign o_busy      = busy_r;

endmodule
